// File: rtl/seg7_scan_decoder.sv
// Reconstructs 4-bit digit values from a multiplexed active-low seven-segment bus.
// Optional macro SEG7_HEX_AF_EN adds decoding of the letters A, b, C, d, E, F.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              a2g,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dig_valid,
  output logic [NUM_DIGITS-1:0]   dig_ovr,
  output logic [NUM_DIGITS-1:0]   dig_err,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [NUM_DIGITS-1:0]   anMeta_q, anSync_q;
  logic [6:0]              segMeta_q, segSync_q;
  logic [1:0]              rstSync_q;
  logic                    runEn;

  logic [1:0]              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              pat_q, pat_d;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q, ovr_q, err_q, seen_q, seen_d;
  logic                    frameDone_q;

  logic                    selLegal, selFound, selMulti;
  logic [IDX_W-1:0]        selIdx;
  logic                    stableMatch, relatch, capture;
  logic [NUM_DIGITS-1:0]   captureMask;
  logic [5:0]              decoded;

  // Returns {err, ovr, value[3:0]} for an active-low {a..g} pattern.
  function automatic logic [5:0] decodeSeg(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'b0000001: r = 6'b00_0000;
      7'b1001111: r = 6'b00_0001;
      7'b0010010: r = 6'b00_0010;
      7'b0000110: r = 6'b00_0011;
      7'b1001100: r = 6'b00_0100;
      7'b0100100: r = 6'b00_0101;
      7'b0100000: r = 6'b00_0110;
      7'b0001111: r = 6'b00_0111;
      7'b0000000: r = 6'b00_1000;
      7'b0000100: r = 6'b00_1001;
      7'b0110111: r = 6'b01_1111;
`ifdef SEG7_HEX_AF_EN
      7'b0001000: r = 6'b00_1010;
      7'b1100000: r = 6'b00_1011;
      7'b0110001: r = 6'b00_1100;
      7'b1000010: r = 6'b00_1101;
      7'b0110000: r = 6'b00_1110;
      7'b0111000: r = 6'b00_1111;
`endif
      default:    r = 6'b10_0000;
    endcase
    return r;
  endfunction

  // Reset release is re-timed so the FSM only starts once runEn rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
      anMeta_q  <= '1;
      anSync_q  <= '1;
      segMeta_q <= '1;
      segSync_q <= '1;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
      anMeta_q  <= an;
      anSync_q  <= anMeta_q;
      segMeta_q <= a2g;
      segSync_q <= segMeta_q;
    end
  end

  assign runEn = rstSync_q[1];

  always_comb begin
    selFound = 1'b0;
    selMulti = 1'b0;
    selIdx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!anSync_q[i]) begin
        if (selFound) selMulti = 1'b1;
        selFound = 1'b1;
        selIdx   = IDX_W'(i);
      end
    end
    selLegal = selFound && !selMulti && runEn;
  end

  assign stableMatch = selLegal && (selIdx == idx_q) && (segSync_q == pat_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    relatch = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE:   relatch = 1'b1;
      SETTLE: begin
        if (stableMatch) begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (cnt_d >= STABLE_MAX) state_d = CAPTURE;
        end else begin
          relatch = 1'b1;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD:    relatch = !stableMatch;
      default: state_d = IDLE;
    endcase
    // Any disturbance restarts the stability window from the current bus contents.
    if (relatch) begin
      if (selLegal) begin
        idx_d   = selIdx;
        pat_d   = segSync_q;
        cnt_d   = 8'd1;
        state_d = (STABLE_MAX <= 8'd1) ? CAPTURE : SETTLE;
      end else begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
    end
  end

  assign decoded = decodeSeg(pat_q);

  always_comb begin
    captureMask = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      captureMask[i] = capture && (idx_q == IDX_W'(i));
    end
  end

  // A capture landing in the clearing cycle survives the frame reset.
  assign seen_d = ((&seen_q) ? '0 : seen_q) | captureMask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q    <= '0;
      valid_q     <= '0;
      ovr_q       <= '0;
      err_q       <= '0;
      seen_q      <= '0;
      frameDone_q <= 1'b0;
    end else begin
      seen_q      <= seen_d;
      frameDone_q <= &seen_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (captureMask[i]) begin
          digits_q[4*i +: 4] <= decoded[3:0];
          ovr_q[i]           <= decoded[4];
          err_q[i]           <= decoded[5];
          valid_q[i]         <= 1'b1;
        end
      end
    end
  end

  assign digits     = digits_q;
  assign dig_valid  = valid_q;
  assign dig_ovr    = ovr_q;
  assign dig_err    = err_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed-vector bench for seg7_scan_decoder; expected values are hand-derived.
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  a2g;
  logic [15:0] digits;
  logic [3:0]  dig_valid;
  logic [3:0]  dig_ovr;
  logic [3:0]  dig_err;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an         (an),
    .a2g        (a2g),
    .digits     (digits),
    .dig_valid  (dig_valid),
    .dig_ovr    (dig_ovr),
    .dig_err    (dig_err),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    an    = 4'b1111;
    a2g   = 7'b1111111;
    waitCycles(3);
    checks++;
    if (digits !== 16'h0000) begin failures++; $display("[TB] FAIL reset_digits actual=%h expected=%h", digits, 16'h0000); end
    checks++;
    if (dig_valid !== 4'b0000) begin failures++; $display("[TB] FAIL reset_valid actual=%b expected=%b", dig_valid, 4'b0000); end
    checks++;
    if (dig_ovr !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ovr actual=%b expected=%b", dig_ovr, 4'b0000); end
    checks++;
    if (dig_err !== 4'b0000) begin failures++; $display("[TB] FAIL reset_err actual=%b expected=%b", dig_err, 4'b0000); end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame actual=%b expected=%b", frame_done, 1'b0); end
    rst_n = 1'b1;
    waitCycles(4);
  endtask

  task automatic test_toggle;
    an = 4'b1101;
    for (int k = 0; k < 10; k++) begin
      a2g = k[0] ? 7'b0000100 : 7'b0000110;
      waitCycles(2);
    end
    an  = 4'b1111;
    a2g = 7'b1111111;
    waitCycles(8);
    checks++;
    if (dig_valid !== 4'b0000) begin failures++; $display("[TB] FAIL toggle_valid actual=%b expected=%b", dig_valid, 4'b0000); end
    checks++;
    if (digits !== 16'h0000) begin failures++; $display("[TB] FAIL toggle_digits actual=%h expected=%h", digits, 16'h0000); end
  endtask

  task automatic test_multi_select;
    an  = 4'b1100;
    a2g = 7'b0000000;
    waitCycles(20);
    checks++;
    if (dig_valid !== 4'b0000) begin failures++; $display("[TB] FAIL multi_valid actual=%b expected=%b", dig_valid, 4'b0000); end
    checks++;
    if (digits !== 16'h0000) begin failures++; $display("[TB] FAIL multi_digits actual=%h expected=%h", digits, 16'h0000); end
    an  = 4'b1111;
    a2g = 7'b1111111;
    waitCycles(4);
  endtask

  task automatic test_single_digit;
    an  = 4'b1110;
    a2g = 7'b0010010;
    waitCycles(6);
    checks++;
    if (dig_valid !== 4'b0000) begin failures++; $display("[TB] FAIL single_early_valid actual=%b expected=%b", dig_valid, 4'b0000); end
    waitCycles(1);
    checks++;
    if (dig_valid !== 4'b0001) begin failures++; $display("[TB] FAIL single_valid actual=%b expected=%b", dig_valid, 4'b0001); end
    checks++;
    if (digits[3:0] !== 4'h2) begin failures++; $display("[TB] FAIL single_value actual=%h expected=%h", digits[3:0], 4'h2); end
    checks++;
    if (dig_err !== 4'b0000 || dig_ovr !== 4'b0000) begin
      failures++; $display("[TB] FAIL single_flags actual_err=%b actual_ovr=%b expected=0000", dig_err, dig_ovr);
    end
    waitCycles(3);
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL single_frame actual=%b expected=%b", frame_done, 1'b0); end
  endtask

  task automatic test_scan;
    logic [6:0] pats [4];
    int cyc;
    int pulseCount;
    int pulseCycle;
    pats[0] = 7'b0000110;
    pats[1] = 7'b0001111;
    pats[2] = 7'b0000100;
    pats[3] = 7'b0110111;
    cyc        = 0;
    pulseCount = 0;
    pulseCycle = -1;
    for (int d = 0; d < 4; d++) begin
      an  = ~(4'b0001 << d);
      a2g = pats[d];
      for (int c = 0; c < 8; c++) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (frame_done === 1'b1) begin pulseCount++; pulseCycle = cyc; end
      end
    end
    an  = 4'b1111;
    a2g = 7'b1111111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (frame_done === 1'b1) begin pulseCount++; pulseCycle = cyc; end
    end
    checks++;
    if (digits !== 16'hF973) begin failures++; $display("[TB] FAIL scan_digits actual=%h expected=%h", digits, 16'hF973); end
    checks++;
    if (dig_ovr !== 4'b1000) begin failures++; $display("[TB] FAIL scan_ovr actual=%b expected=%b", dig_ovr, 4'b1000); end
    checks++;
    if (dig_err !== 4'b0000) begin failures++; $display("[TB] FAIL scan_err actual=%b expected=%b", dig_err, 4'b0000); end
    checks++;
    if (dig_valid !== 4'b1111) begin failures++; $display("[TB] FAIL scan_valid actual=%b expected=%b", dig_valid, 4'b1111); end
    checks++;
    if (pulseCount != 1) begin failures++; $display("[TB] FAIL scan_pulse_count actual=%0d expected=%0d", pulseCount, 1); end
    checks++;
    if (pulseCycle != 32) begin failures++; $display("[TB] FAIL scan_pulse_cycle actual=%0d expected=%0d", pulseCycle, 32); end
  endtask

  task automatic test_error;
    an  = 4'b1101;
    a2g = 7'b1111111;
    waitCycles(10);
    checks++;
    if (dig_err[1] !== 1'b1) begin failures++; $display("[TB] FAIL err_flag actual=%b expected=%b", dig_err[1], 1'b1); end
    checks++;
    if (digits[7:4] !== 4'h0) begin failures++; $display("[TB] FAIL err_value actual=%h expected=%h", digits[7:4], 4'h0); end
    a2g = 7'b1001111;
    waitCycles(10);
    checks++;
    if (dig_err[1] !== 1'b0) begin failures++; $display("[TB] FAIL err_clear actual=%b expected=%b", dig_err[1], 1'b0); end
    checks++;
    if (digits[7:4] !== 4'h1) begin failures++; $display("[TB] FAIL err_recover_value actual=%h expected=%h", digits[7:4], 4'h1); end
    checks++;
    if (digits[3:0] !== 4'h3) begin failures++; $display("[TB] FAIL err_other_digit actual=%h expected=%h", digits[3:0], 4'h3); end
    an  = 4'b1111;
    a2g = 7'b1111111;
    waitCycles(2);
  endtask

  task automatic test_reset_mid_settle;
    an  = 4'b1011;
    a2g = 7'b0000000;
    waitCycles(4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (digits !== 16'h0000) begin failures++; $display("[TB] FAIL midrst_digits actual=%h expected=%h", digits, 16'h0000); end
    checks++;
    if (dig_valid !== 4'b0000 || dig_ovr !== 4'b0000 || dig_err !== 4'b0000) begin
      failures++; $display("[TB] FAIL midrst_flags actual_valid=%b ovr=%b err=%b expected=0000", dig_valid, dig_ovr, dig_err);
    end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_frame actual=%b expected=%b", frame_done, 1'b0); end
    an  = 4'b1111;
    a2g = 7'b1111111;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(3);
    an  = 4'b1011;
    a2g = 7'b0001000;
    waitCycles(10);
    checks++;
    if (dig_valid !== 4'b0100) begin failures++; $display("[TB] FAIL letter_valid actual=%b expected=%b", dig_valid, 4'b0100); end
    checks++;
    if (dig_ovr[2] !== 1'b0) begin failures++; $display("[TB] FAIL letter_ovr actual=%b expected=%b", dig_ovr[2], 1'b0); end
`ifdef SEG7_HEX_AF_EN
    checks++;
    if (digits[11:8] !== 4'hA) begin failures++; $display("[TB] FAIL letter_value actual=%h expected=%h", digits[11:8], 4'hA); end
    checks++;
    if (dig_err[2] !== 1'b0) begin failures++; $display("[TB] FAIL letter_err actual=%b expected=%b", dig_err[2], 1'b0); end
`else
    checks++;
    if (digits[11:8] !== 4'h0) begin failures++; $display("[TB] FAIL letter_value actual=%h expected=%h", digits[11:8], 4'h0); end
    checks++;
    if (dig_err[2] !== 1'b1) begin failures++; $display("[TB] FAIL letter_err actual=%b expected=%b", dig_err[2], 1'b1); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 4'b1111;
    a2g   = 7'b1111111;
    @(negedge clk);
    test_reset;
    test_toggle;
    test_multi_select;
    test_single_digit;
    test_scan;
    test_error;
    test_reset_mid_settle;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
